// File: rtl/if_fetch_stage_if.sv
// Bus bundle for the fetch stage: imem request/response, redirect and decode channels.
// Handshakes: a transfer happens on a rising edge where valid && ready; the sender holds its payload while valid && !ready.
interface if_fetch_stage_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_inst, id_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_inst, id_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/if_fetch_stage.sv
// RV32I instruction-fetch stage: PC, credit-limited imem requests, in-flight PC queue, output FIFO.
// Optional macro IF_PERF_CNT_EN adds fetch_cnt/flush_cnt performance counters.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  if_fetch_stage_if.master  bus
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       flush_cnt
`endif
);
  localparam int            CW   = $clog2(DEPTH + 1);
  localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW:0]   CAP  = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] fifo_count;
  logic [PW-1:0] pq_wr, pq_rd, ff_wr, ff_rd;
  logic [31:0]   pq_mem  [DEPTH];
  logic [31:0]   ff_pc   [DEPTH];
  logic [31:0]   ff_inst [DEPTH];

  logic redirect, credit_ok, req_fire, resp_fire, resp_keep, id_fire;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign redirect  = bus.redirect_valid;
  // Credit covers both in-flight requests and buffered entries, so the FIFO can never overflow.
  assign credit_ok = ({1'b0, outstanding} + {1'b0, fifo_count}) < CAP;
  assign req_fire  = bus.imem_req_valid && bus.imem_req_ready;
  assign resp_fire = bus.imem_resp_valid && (outstanding != '0);
  assign resp_keep = resp_fire && !redirect && (drop_cnt == '0);
  assign id_fire   = bus.id_valid && bus.id_ready && !redirect;

  assign bus.imem_req_valid = !rst && !redirect && credit_ok;
  assign bus.imem_req_addr  = fetch_pc;
  assign bus.id_valid       = (fifo_count != '0);
  assign bus.id_inst        = bus.id_valid ? ff_inst[ff_rd] : 32'h0;
  assign bus.id_pc          = bus.id_valid ? ff_pc[ff_rd]   : 32'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
    end else if (redirect) begin
      fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
    end else if (req_fire) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
      drop_cnt    <= '0;
      pq_wr       <= '0;
      pq_rd       <= '0;
    end else begin
      case ({req_fire, resp_fire})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      // Every response still pending at a redirect belongs to the wrong path.
      if (redirect) begin
        drop_cnt <= outstanding - CW'(resp_fire);
      end else if (resp_fire && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - 1'b1;
      end
      if (req_fire)  pq_wr <= ptr_inc(pq_wr);
      if (resp_fire) pq_rd <= ptr_inc(pq_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) pq_mem[pq_wr] <= fetch_pc;
    if (resp_keep) begin
      ff_pc[ff_wr]   <= pq_mem[pq_rd];
      ff_inst[ff_wr] <= bus.imem_resp_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff_wr      <= '0;
      ff_rd      <= '0;
      fifo_count <= '0;
    end else if (redirect) begin
      ff_wr      <= '0;
      ff_rd      <= '0;
      fifo_count <= '0;
    end else begin
      if (resp_keep) ff_wr <= ptr_inc(ff_wr);
      if (id_fire)   ff_rd <= ptr_inc(ff_rd);
      case ({resp_keep, id_fire})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      fetch_cnt <= fetch_cnt + 32'(id_fire);
      flush_cnt <= flush_cnt
                 + 32'(resp_fire && (redirect || (drop_cnt != '0)))
                 + (redirect ? 32'(fifo_count) : 32'h0);
    end
  end
`endif
endmodule
